// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register, issues one instruction fetch at a time,
// hands instructions to decode and applies trap/mret/branch redirects.
module pc_fetch_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int INSN_BYTES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W-1:0] PC_IN,
  output logic              PC_WRITE,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic              TRAP,
  input  logic [ADDR_W-1:0] TRAP_VEC,
  input  logic              MRET,
  input  logic [ADDR_W-1:0] EPC,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_READY,
  input  logic              IMEM_RVALID,
  input  logic [31:0]       IMEM_RDATA,
  output logic              IF_VALID,
  output logic [31:0]       IF_INSTR,
  output logic [ADDR_W-1:0] IF_PC,
  input  logic              IF_READY,
  output logic              FLUSH
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;

  logic                redirect_s;
  logic [ADDR_W-1:0]   target_s;

  // Redirect detection and fixed-priority target select, word aligned
  always_comb begin
    redirect_s = TRAP | MRET | BR_TAKEN;
    if (TRAP) begin
      target_s = TRAP_VEC;
    end else if (MRET) begin
      target_s = EPC;
    end else begin
      target_s = BR_TARGET;
    end
    target_s[1:0] = 2'b00;
  end

  // Next-state logic and combinational PC/fetch/flush outputs
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    PC_IN      = {ADDR_W{1'b0}};
    PC_WRITE   = 1'b0;
    FLUSH      = 1'b0;
    IMEM_REQ   = 1'b0;
    IMEM_ADDR  = PC_OUT;

    if (RESET) begin
      // Outputs stay quiet while reset is held; the flops are cleared asynchronously
      PC_WRITE = 1'b0;
    end else begin
      IMEM_REQ = (state_q == S_REQ) & ~redirect_s;
      if (redirect_s) begin
        PC_WRITE = 1'b1;
        PC_IN    = target_s;
        FLUSH    = 1'b1;
      end else begin
        FLUSH    = 1'b0;
      end

      case (state_q)
        S_REQ: begin
          if (!redirect_s && IMEM_READY) begin
            PC_WRITE   = 1'b1;
            PC_IN      = PC_OUT + ADDR_W'(INSN_BYTES);
            fetch_pc_d = PC_OUT;
            state_d    = S_WAIT;
          end else begin
            state_d    = S_REQ;
          end
        end
        S_WAIT: begin
          if (redirect_s) begin
            state_d = IMEM_RVALID ? S_REQ : S_DRAIN;
          end else if (IMEM_RVALID) begin
            if_instr_d = IMEM_RDATA;
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            state_d    = S_OUT;
          end else begin
            state_d    = S_WAIT;
          end
        end
        S_OUT: begin
          // A redirect kills the held instruction even when decode is ready
          if (redirect_s || IF_READY) begin
            if_valid_d = 1'b0;
            state_d    = S_REQ;
          end else begin
            state_d    = S_OUT;
          end
        end
        S_DRAIN: begin
          if (IMEM_RVALID) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      endcase
    end
  end

  // State and decode-side output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_REQ;
      fetch_pc_q <= {ADDR_W{1'b0}};
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0000_0000;
      if_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign IF_VALID = if_valid_q;
  assign IF_INSTR = if_instr_q;
  assign IF_PC    = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with a behavioural PC register.
module tb_pc_fetch_ctrl;

  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] PC_OUT, PC_IN, BR_TARGET, TRAP_VEC, EPC, IMEM_ADDR, IF_PC;
  logic          PC_WRITE, BR_TAKEN, TRAP, MRET, IMEM_REQ, IMEM_READY, IMEM_RVALID;
  logic [31:0]   IMEM_RDATA, IF_INSTR;
  logic          IF_VALID, IF_READY, FLUSH;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  pc_fetch_ctrl #(.ADDR_W(AW), .INSN_BYTES(4)) dut (
    .CLK(CLK), .RESET(RESET), .PC_OUT(PC_OUT), .PC_IN(PC_IN), .PC_WRITE(PC_WRITE),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .TRAP(TRAP), .TRAP_VEC(TRAP_VEC),
    .MRET(MRET), .EPC(EPC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_READY(IMEM_READY), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .IF_READY(IF_READY),
    .FLUSH(FLUSH)
  );

  // PC register sitting next to the sequencer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)         PC_OUT <= 32'h0;
    else if (PC_WRITE) PC_OUT <= PC_IN;
  end

  typedef struct {
    logic        br;   logic [31:0] tgt; logic trap; logic mret;
    logic        rdy;  logic rv; logic [31:0] rdata; logic ifr;
    logic [31:0] e_pcin; logic e_pcw; logic e_flush; logic e_req;
    logic [31:0] e_addr; logic e_ifv; logic [31:0] e_instr; logic [31:0] e_ifpc;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic br, input logic [31:0] tgt, input logic trap, input logic mret,
                     input logic rdy, input logic rv, input logic [31:0] rdata, input logic ifr,
                     input logic [31:0] pcin, input logic pcw, input logic fl, input logic req,
                     input logic [31:0] addr, input logic ifv, input logic [31:0] ins,
                     input logic [31:0] ifpc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.trap = trap; v.mret = mret; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.ifr = ifr; v.e_pcin = pcin; v.e_pcw = pcw; v.e_flush = fl;
    v.e_req = req; v.e_addr = addr; v.e_ifv = ifv; v.e_instr = ins; v.e_ifpc = ifpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic trap, input logic mret,
                       input logic rdy, input logic rv, input logic [31:0] rdata, input logic ifr);
    BR_TAKEN = br; BR_TARGET = tgt; TRAP = trap; MRET = mret;
    IMEM_READY = rdy; IMEM_RVALID = rv; IMEM_RDATA = rdata; IF_READY = ifr;
  endtask

  localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0010_0093, A2 = 32'h0020_0113;
  localparam logic [31:0] A3 = 32'h0030_0193, D4 = 32'h0040_0213, E0 = 32'h0050_0293;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    TRAP_VEC = 32'h200; EPC = 32'h300;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    RESET = 1'b1;

    //  br tgt           tr    mr    rdy   rv    rdata ifr   pc_in          pcw   flush req   addr           ifv   instr ifpc
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,         1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0, 32'h0);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, A0,    1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h4,         1'b0, 32'h0, 32'h0);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h4,         1'b1, A0,    32'h0);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,         1'b1, 1'b0, 1'b1, 32'h4,         1'b0, A0,    32'h0);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, A1,    1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h8,         1'b0, A0,    32'h0);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h8,         1'b1, A1,    32'h4);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hC,         1'b1, 1'b0, 1'b1, 32'h8,         1'b0, A1,    32'h4);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, A2,    1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'hC,         1'b0, A1,    32'h4);
    for (int i = 0; i < 5; i++)
      row(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hC,         1'b1, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'hC,         1'b1, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 32'hC,         1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10,        1'b1, 1'b0, 1'b1, 32'hC,         1'b0, A2,    32'h8);
    row(1'b1, 32'h100,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100,       1'b1, 1'b1, 1'b0, 32'h10,        1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h100,       1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h100,       1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, BAD,   1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h100,       1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104,       1'b1, 1'b0, 1'b1, 32'h100,       1'b0, A2,    32'h8);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, A3,    1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       1'b0, A2,    32'h8);
    row(1'b1, 32'h100,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200,       1'b1, 1'b1, 1'b0, 32'h104,       1'b1, A3,    32'h100);
    row(1'b1, 32'h100,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300,       1'b1, 1'b1, 1'b0, 32'h200,       1'b0, A3,    32'h100);
    row(1'b1, 32'h103,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100,       1'b1, 1'b1, 1'b0, 32'h300,       1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104,       1'b1, 1'b0, 1'b1, 32'h100,       1'b0, A3,    32'h100);
    row(1'b1, 32'h40,    1'b0, 1'b0, 1'b0, 1'b1, BAD,   1'b1, 32'h40,        1'b1, 1'b1, 1'b0, 32'h104,       1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, BAD,   1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 32'h40,        1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h44,        1'b1, 1'b0, 1'b1, 32'h40,        1'b0, A3,    32'h100);
    row(1'b1, 32'h80,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80,        1'b1, 1'b1, 1'b0, 32'h44,        1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200,       1'b1, 1'b1, 1'b0, 32'h80,        1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, BAD,   1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h200,       1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h204,       1'b1, 1'b0, 1'b1, 32'h200,       1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, D4,    1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h204,       1'b0, A3,    32'h100);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h204,       1'b1, D4,    32'h200);
    row(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h204,   1'b1, D4,    32'h200);
    row(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, D4,    32'h200);
    row(1'b1, 32'h10,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10,        1'b1, 1'b1, 1'b0, 32'h0,         1'b0, D4,    32'h200);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_if_valid", -1, {31'h0, IF_VALID}, 32'h0);
    chk("rst_pc_write", -1, {31'h0, PC_WRITE}, 32'h0);
    chk("rst_imem_req", -1, {31'h0, IMEM_REQ}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].br, vecs[i].tgt, vecs[i].trap, vecs[i].mret,
            vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].ifr);
      #1;
      chk("pc_in",     i, PC_IN,              vecs[i].e_pcin);
      chk("pc_write",  i, {31'h0, PC_WRITE},  {31'h0, vecs[i].e_pcw});
      chk("flush",     i, {31'h0, FLUSH},     {31'h0, vecs[i].e_flush});
      chk("imem_req",  i, {31'h0, IMEM_REQ},  {31'h0, vecs[i].e_req});
      chk("imem_addr", i, IMEM_ADDR,          vecs[i].e_addr);
      chk("if_valid",  i, {31'h0, IF_VALID},  {31'h0, vecs[i].e_ifv});
      chk("if_instr",  i, IF_INSTR,           vecs[i].e_instr);
      chk("if_pc",     i, IF_PC,              vecs[i].e_ifpc);
    end

    // Now in DRAIN: redirect raises FLUSH, then an asynchronous reset mid-cycle
    @(negedge CLK);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("drain_flush", 100, {31'h0, FLUSH}, 32'h1);
    #1;
    RESET = 1'b1;
    #1;
    chk("async_flush",    101, {31'h0, FLUSH},    32'h0);
    chk("async_pc_write", 101, {31'h0, PC_WRITE}, 32'h0);
    chk("async_if_valid", 101, {31'h0, IF_VALID}, 32'h0);
    chk("async_if_instr", 101, IF_INSTR,          32'h0);
    chk("async_if_pc",    101, IF_PC,             32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, BAD, 1'b1);
    #1;
    chk("post_rst_req",  102, {31'h0, IMEM_REQ}, 32'h1);
    chk("post_rst_addr", 102, IMEM_ADDR,         32'h0);
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("post_rst_ifv",  103, {31'h0, IF_VALID}, 32'h0);
    chk("post_rst_addr", 103, IMEM_ADDR,         32'h0);
    chk("post_rst_pcin", 103, PC_IN,             32'h4);
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, E0, 1'b1);
    #1;
    chk("post_rst_wait_ifv", 104, {31'h0, IF_VALID}, 32'h0);
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("post_rst_out_ifv",   105, {31'h0, IF_VALID}, 32'h1);
    chk("post_rst_out_instr", 105, IF_INSTR,          E0);
    chk("post_rst_out_pc",    105, IF_PC,             32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
